// File: rtl/piano_tone_engine.sv
// Debounced, priority-encoded square-wave tone generator for up to 14 note keys.
// Retune and release only take effect on half-period boundaries so no pulse is ever truncated.
module piano_tone_engine #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned NUM_KEYS        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          octave,
  input  logic                enable,
  output logic                speaker,
  output logic                note_active,
  output logic [3:0]          note_idx,
  output logic [NUM_KEYS-1:0] key_led
);

  function automatic int unsigned half_of(input int unsigned d);
    int unsigned f;
    case (d)
      0:       f = 262;
      1:       f = 294;
      2:       f = 330;
      3:       f = 349;
      4:       f = 392;
      5:       f = 440;
      default: f = 494;
    endcase
    return CLK_HZ / (2 * f);
  endfunction

  localparam int unsigned CW = $clog2(2 * half_of(0) + 1);
  localparam int unsigned TW = $clog2(DEBOUNCE_CYCLES);

  function automatic logic [CW-1:0] base_of(input int unsigned k);
    return CW'(half_of(k % 7) >> (k / 7));
  endfunction

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

  logic [NUM_KEYS-1:0] sync1, sync2, samp, db;
  logic [TW-1:0]       tick_cnt;
  logic                tick;

  state_t        state, state_n;
  logic [CW-1:0] phase, phase_n, hp, hp_n;
  logic [3:0]    idx_n;
  logic [1:0]    lat_oct, lat_oct_n;
  logic          spk_n;

  logic [3:0]    req;
  logic          found, req_valid;
  logic [1:0]    oct_sel;
  logic [CW-1:0] hp_base, hp_req;
  logic          toggle, retune;

  assign tick    = (tick_cnt == TW'(DEBOUNCE_CYCLES - 1));
  assign key_led = db;

  // Debounce: a bit only moves when two consecutive tick samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      samp     <= '0;
      db       <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        samp <= sync2;
        db   <= (~(sync2 ^ samp) & sync2) | ((sync2 ^ samp) & db);
      end
    end
  end

  always_comb begin
    req   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (db[i] && !found) begin
        req   = 4'(i);
        found = 1'b1;
      end
    end
    req_valid = enable & found;

    oct_sel = (octave == 2'd3) ? 2'd2 : octave;
    hp_base = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (req == 4'(i)) hp_base = base_of(i);
    end
    case (oct_sel)
      2'd0:    hp_req = hp_base << 1;
      2'd1:    hp_req = hp_base;
      default: hp_req = hp_base >> 1;
    endcase
  end

  assign toggle = (phase == hp - CW'(1));
  assign retune = req_valid && ((req != note_idx) || (oct_sel != lat_oct));

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    hp_n      = hp;
    idx_n     = note_idx;
    lat_oct_n = lat_oct;
    spk_n     = speaker;
    case (state)
      IDLE: begin
        spk_n   = 1'b0;
        phase_n = '0;
        if (req_valid) begin
          hp_n      = hp_req;
          idx_n     = req;
          lat_oct_n = oct_sel;
          state_n   = PLAY;
        end
      end
      PLAY: begin
        if (toggle) begin
          spk_n   = ~speaker;
          phase_n = '0;
          // retune is gated by req_valid, so a release on this toggle suppresses it
          if (retune) begin
            hp_n      = hp_req;
            idx_n     = req;
            lat_oct_n = oct_sel;
          end
        end else begin
          phase_n = phase + CW'(1);
        end
        if (!req_valid) state_n = RELEASE;
      end
      default: begin
        if (toggle) begin
          spk_n   = ~speaker;
          phase_n = '0;
          if (speaker && !req_valid) begin
            state_n   = IDLE;
            idx_n     = '0;
            lat_oct_n = '0;
          end
        end else begin
          phase_n = phase + CW'(1);
        end
        if (req_valid) state_n = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      hp          <= '0;
      note_idx    <= '0;
      lat_oct     <= '0;
      speaker     <= 1'b0;
      note_active <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      hp          <= hp_n;
      note_idx    <= idx_n;
      lat_oct     <= lat_oct_n;
      speaker     <= spk_n;
      note_active <= (state_n == PLAY);
    end
  end

endmodule

// File: tb/tb_piano_tone_engine.sv
// Directed bench for piano_tone_engine at CLK_HZ=1 MHz, 14 keys, 4-clock debounce tick.
module tb_piano_tone_engine;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] key = '0;
  logic [1:0]  octave = 2'd1;
  logic        enable = 1'b1;
  logic        speaker, note_active;
  logic [3:0]  note_idx;
  logic [13:0] key_led;

  piano_tone_engine #(
    .CLK_HZ(1_000_000),
    .NUM_KEYS(14),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .octave(octave),
    .enable(enable),
    .speaker(speaker),
    .note_active(note_active),
    .note_idx(note_idx),
    .key_led(key_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Speaker edge monitor: last_len is the length in clocks of the level that just ended.
  logic prev_spk = 1'b0;
  int   run = 0;
  int   last_len = 0;
  int   tog = 0;
  always @(negedge clk) begin
    if (speaker !== prev_spk) begin
      last_len = run;
      run      = 1;
      prev_spk = speaker;
      tog      = tog + 1;
    end else begin
      run = run + 1;
    end
  end

  typedef struct {
    logic [13:0] k;
    logic [1:0]  oct;
    int          hp;
    int          idx;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_active(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (note_active === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_toggle(input int budget, output bit ok);
    int start;
    start = tog;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (tog != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int n, led_changes, quiet_tog;
    bit early;
    logic [13:0] prev_led;

    vecs[0] = '{14'h0020, 2'd1, 1136, 5};
    vecs[1] = '{14'h0020, 2'd0, 2272, 5};
    vecs[2] = '{14'h0020, 2'd3,  568, 5};
    vecs[3] = '{14'h0021, 2'd1, 1908, 0};
    vecs[4] = '{14'h0080, 2'd1,  954, 7};
    vecs[5] = '{14'h2000, 2'd2,  253, 13};
    vecs[6] = '{14'h0040, 2'd2,  506, 6};

    // Reset overrides pressed keys
    key = '1;
    step();
    step();
    step();
    check("reset_speaker", speaker, 0);
    check("reset_active", note_active, 0);
    check("reset_idx", note_idx, 0);
    check("reset_led", key_led, 0);
    key = '0;
    step();
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      key = '0;
      do_reset();
      key    = vecs[v].k;
      octave = vecs[v].oct;
      wait_active(40, ok);
      check("vec_active", ok, 1);
      check("vec_idx", note_idx, vecs[v].idx);
      check("vec_led", key_led, vecs[v].k);
      n = 0;
      while (speaker !== 1'b1 && n < 3 * vecs[v].hp + 10) begin
        step();
        n++;
      end
      check("vec_first_rise", n, vecs[v].hp);
      wait_toggle(3 * vecs[v].hp, ok);
      check("vec_high_len", last_len, vecs[v].hp);
      wait_toggle(3 * vecs[v].hp, ok);
      check("vec_low_len", last_len, vecs[v].hp);
    end

    // Bounce rejection: key 2 toggles every D clocks so consecutive tick samples never agree
    key = '0;
    octave = 2'd1;
    do_reset();
    prev_led = key_led;
    led_changes = 0;
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      key[2] = ((i / 4) % 2 == 0);
      step();
      if (key_led != prev_led) led_changes++;
      prev_led = key_led;
      if (note_active) early = 1'b1;
    end
    check("bounce_no_note", early, 0);
    key[2] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2 * D + 3; i++) begin
      step();
      if (key_led != prev_led) led_changes++;
      prev_led = key_led;
      if (note_active) begin
        ok = 1'b1;
        break;
      end
    end
    check("bounce_start_bound", ok, 1);
    check("bounce_db_changes", led_changes, 1);
    check("bounce_led", key_led, 14'h0004);
    check("bounce_idx", note_idx, 2);

    // Glitch-free retune from key 5 to key 0 mid half-period
    key = '0;
    do_reset();
    key = 14'h0020;
    wait_active(40, ok);
    wait_toggle(3000, ok);
    repeat (500) step();
    key = 14'h0001;
    wait_toggle(3000, ok);
    check("retune_current_len", last_len, 1136);
    check("retune_idx", note_idx, 0);
    wait_toggle(5000, ok);
    check("retune_next_len", last_len, 1908);

    // Release while speaker low: one full high then silence
    key = '0;
    do_reset();
    key = 14'h0020;
    wait_active(40, ok);
    wait_toggle(3000, ok);
    wait_toggle(3000, ok);
    check("rel_low_level", speaker, 0);
    repeat (100) step();
    key = '0;
    repeat (15) step();
    check("rel_inactive", note_active, 0);
    check("rel_idx_hold", note_idx, 5);
    wait_toggle(3000, ok);
    check("rel_low_len", last_len, 1136);
    check("rel_rise", speaker, 1);
    wait_toggle(3000, ok);
    check("rel_high_len", last_len, 1136);
    check("rel_end_speaker", speaker, 0);
    check("rel_end_idx", note_idx, 0);
    quiet_tog = tog;
    repeat (3000) step();
    check("rel_quiet", tog - quiet_tog, 0);

    // Mute while speaker high with key held
    key = '0;
    do_reset();
    key = 14'h0020;
    wait_active(40, ok);
    wait_toggle(3000, ok);
    repeat (200) step();
    enable = 1'b0;
    step();
    step();
    check("mute_inactive", note_active, 0);
    wait_toggle(3000, ok);
    check("mute_high_len", last_len, 1136);
    check("mute_end_speaker", speaker, 0);
    check("mute_end_idx", note_idx, 0);
    quiet_tog = tog;
    repeat (3000) step();
    check("mute_quiet", tog - quiet_tog, 0);
    enable = 1'b1;

    // Reset mid-note with speaker high; key still held afterwards
    key = '0;
    do_reset();
    key = 14'h0020;
    wait_active(40, ok);
    wait_toggle(3000, ok);
    repeat (50) step();
    rst = 1'b1;
    step();
    check("midrst_speaker", speaker, 0);
    check("midrst_active", note_active, 0);
    check("midrst_idx", note_idx, 0);
    check("midrst_led", key_led, 0);
    rst = 1'b0;
    wait_active(2 * D + 6, ok);
    check("midrst_resume", ok, 1);
    check("midrst_resume_idx", note_idx, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
